// File: rtl/mem_lsu_if.sv
// Data-RAM request/ack bus between the load/store unit (master) and the memory (slave).
interface mem_lsu_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              mem_ce_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [3:0]        mem_sel_o;
   logic [31:0]       mem_data_o;
   logic              mem_ack_i;
   logic [31:0]       mem_data_i;

   modport master (
      output mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o,
      input  mem_ack_i, mem_data_i
   );

   modport slave (
      input  mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o,
      output mem_ack_i, mem_data_i
   );
endinterface

// File: rtl/mem_lsu.sv
// Multi-cycle big-endian load/store unit with a variable-latency RAM bus and a one-cycle IO window.
// Optional bus-wait timeout enabled by defining MEM_LSU_TIMEOUT_EN.
module mem_lsu #(
   parameter int unsigned       ADDR_W  = 32,
   parameter logic [ADDR_W-1:0] IO_BASE = 32'hFFFF_0000,
   parameter logic [ADDR_W-1:0] IO_MASK = 32'hFFFF_0000,
   parameter int unsigned       TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        op_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   input  logic [4:0]        wd_i,
   input  logic              wreg_i,
   output logic              stall_req,
   output logic              wb_valid,
   output logic [4:0]        wd_o,
   output logic              wreg_o,
   output logic [31:0]       wdata_o,
   mem_lsu_if.master         bus,
   output logic              io_we,
   output logic              io_re,
   output logic [31:0]       data_out,
   input  logic [31:0]       data_in,
   output logic              misalign_o,
   output logic              bus_err_o
);
   localparam logic [2:0] OP_LB = 3'd0, OP_LBU = 3'd1, OP_LH = 3'd2, OP_LHU = 3'd3;
   localparam logic [2:0] OP_LW = 3'd4, OP_SB = 3'd5, OP_SH = 3'd6, OP_SW = 3'd7;

   if (TIMEOUT < 1) begin : g_timeout_chk
      $error("mem_lsu: TIMEOUT must be >= 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_IO, S_DONE} state_t;

   function automatic logic is_store(input logic [2:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
      case (op)
         OP_LH, OP_LHU, OP_SH: return a[0];
         OP_LW, OP_SW:         return a != 2'b00;
         default:              return 1'b0;
      endcase
   endfunction

   // Big-endian lanes: byte offset 0 lives in bits 31:24.
   function automatic logic [3:0] sel_of(input logic [2:0] op, input logic [1:0] a);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 4'b1000 >> a;
         OP_LH, OP_LHU, OP_SH: return a[1] ? 4'b0011 : 4'b1100;
         default:              return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] w);
      case (op)
         OP_SB:   return {4{w[7:0]}};
         OP_SH:   return {2{w[15:0]}};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] a,
                                            input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      case (a)
         2'd0:    b = d[31:24];
         2'd1:    b = d[23:16];
         2'd2:    b = d[15:8];
         default: b = d[7:0];
      endcase
      h = a[1] ? d[15:0] : d[31:16];
      case (op)
         OP_LB:   return {{24{b[7]}}, b};
         OP_LBU:  return {24'd0, b};
         OP_LH:   return {{16{h[15]}}, h};
         OP_LHU:  return {16'd0, h};
         default: return d;
      endcase
   endfunction

   state_t            state, state_n;
   logic              accept, timeout_hit, mis_r, err_q, store_r;
   logic [2:0]        op_r;
   logic [ADDR_W-1:0] addr_r;
   logic [31:0]       wdata_r, rdata_r, st_data;
   logic [4:0]        wd_r;
   logic              wreg_r;

   assign accept  = (state == S_IDLE) && req_valid;
   assign store_r = is_store(op_r);
   assign st_data = store_data(op_r, wdata_r);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         mis_r <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) mis_r <= misaligned(op_i, addr_i[1:0]);
      end
   end

   // Request fields and returned data carry no reset; every output using them is state-gated.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_r    <= op_i;
         addr_r  <= addr_i;
         wdata_r <= wdata_i;
         wd_r    <= wd_i;
         wreg_r  <= wreg_i;
      end
      if (state == S_BUS && bus.mem_ack_i) rdata_r <= bus.mem_data_i;
      if (state == S_IO) rdata_r <= data_in;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: if (req_valid) begin
            if (misaligned(op_i, addr_i[1:0]))      state_n = S_DONE;
            else if ((addr_i & IO_MASK) == IO_BASE) state_n = S_IO;
            else                                    state_n = S_BUS;
         end
         S_BUS:   if (bus.mem_ack_i || timeout_hit) state_n = S_DONE;
         S_IO:    state_n = S_DONE;
         default: state_n = S_IDLE;
      endcase
   end

`ifdef MEM_LSU_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt;

   assign timeout_hit = (state == S_BUS) && !bus.mem_ack_i && (cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt   <= '0;
         err_q <= 1'b0;
      end else begin
         if (state != S_BUS)     cnt <= '0;
         else if (!bus.mem_ack_i) cnt <= cnt + CNT_W'(1);
         if (accept)           err_q <= 1'b0;
         else if (timeout_hit) err_q <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign err_q       = 1'b0;
`endif

   assign req_ready      = (state == S_IDLE);
   assign stall_req      = accept || (state == S_BUS) || (state == S_IO);
   assign bus.mem_ce_o   = (state == S_BUS);
   assign bus.mem_we_o   = (state == S_BUS) && store_r;
   assign bus.mem_addr_o = (state == S_BUS) ? {addr_r[ADDR_W-1:2], 2'b00} : '0;
   assign bus.mem_sel_o  = (state == S_BUS) ? sel_of(op_r, addr_r[1:0]) : 4'b0000;
   assign bus.mem_data_o = (state == S_BUS) ? st_data : 32'd0;
   assign io_re          = (state == S_IO) && !store_r;
   assign io_we          = (state == S_IO) && store_r;
   assign data_out       = io_we ? st_data : 32'd0;
   assign wb_valid       = (state == S_DONE);
   assign wd_o           = wb_valid ? wd_r : 5'd0;
   assign wreg_o         = wb_valid && wreg_r && !store_r && !mis_r && !err_q;
   assign wdata_o        = (wb_valid && !store_r && !mis_r && !err_q) ?
                           load_ext(op_r, addr_r[1:0], rdata_r) : 32'd0;
   assign misalign_o     = wb_valid && mis_r;
   assign bus_err_o      = wb_valid && err_q;
endmodule
